// File: rtl/replacement_ctrl.sv
// replacement_ctrl: sequences cache hit/miss handling, victim refill and replacement-policy updates
module replacement_ctrl #(
   parameter int N_WAYS     = 8,
   parameter int LINE_OFF_W = 7,
   parameter int NWAY_W     = $clog2(N_WAYS),
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  acc_valid,
   output logic                  acc_ready,
   input  logic [LINE_OFF_W-1:0] acc_line,
   input  logic [N_WAYS-1:0]     acc_hit,
   output logic                  rp_write_en,
   output logic [N_WAYS-1:0]     rp_way_hit,
   output logic [LINE_OFF_W-1:0] rp_line_addr,
   input  logic [N_WAYS-1:0]     rp_way_select,
   input  logic [NWAY_W-1:0]     rp_way_select_bin,
   output logic                  refill_req,
   output logic [NWAY_W-1:0]     refill_way,
   output logic [LINE_OFF_W-1:0] refill_line,
   input  logic                  refill_ack,
   output logic [CNT_W-1:0]      hit_cnt,
   output logic [CNT_W-1:0]      miss_cnt,
   input  logic                  cnt_clr,
   output logic                  err_multi_hit
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SELECT = 2'd1;
   localparam logic [1:0] REFILL = 2'd2;
   localparam logic [1:0] UPDATE = 2'd3;
   logic [1:0]            state_q, state_d;
   logic [LINE_OFF_W-1:0] line_q, line_d;
   logic [N_WAYS-1:0]     hit_q, hit_d;
   logic [NWAY_W-1:0]     vict_q, vict_d;
   logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   logic                  err_q, err_d;
   logic                  acc_ok, is_hit, unused_sel;
   assign unused_sel = ^rp_way_select;
   assign acc_ok = acc_valid & acc_ready;
   assign is_hit = |acc_hit;
   always_comb begin
      state_d    = (state_q == IDLE)   ? (acc_ok ? (is_hit ? UPDATE : SELECT) : IDLE) :
                   (state_q == SELECT) ? REFILL :
                   (state_q == REFILL) ? (refill_ack ? UPDATE : REFILL) : IDLE;
      line_d     = acc_ok ? acc_line : line_q;
      hit_d      = acc_ok ? acc_hit : hit_q;
      vict_d     = (state_q == SELECT) ? rp_way_select_bin : vict_q;
      hit_cnt_d  = cnt_clr ? '0 : (acc_ok & is_hit & ~&hit_cnt_q) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
      miss_cnt_d = cnt_clr ? '0 : (acc_ok & ~is_hit & ~&miss_cnt_q) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
      err_d      = err_q | (acc_ok & |(acc_hit & (acc_hit - N_WAYS'(1))));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         line_q     <= '0;
         hit_q      <= '0;
         vict_q     <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         line_q     <= line_d;
         hit_q      <= hit_d;
         vict_q     <= vict_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         err_q      <= err_d;
      end
   end
   assign acc_ready     = state_q == IDLE;
   assign rp_write_en   = state_q == UPDATE;
   // a miss leaves hit_q all-zero, so UPDATE then reports the refilled victim way
   assign rp_way_hit    = rp_write_en ? (|hit_q ? hit_q : N_WAYS'(1) << vict_q) : '0;
   assign rp_line_addr  = line_q;
   assign refill_req    = state_q == REFILL;
   assign refill_way    = vict_q;
   assign refill_line   = line_q;
   assign hit_cnt       = hit_cnt_q;
   assign miss_cnt      = miss_cnt_q;
   assign err_multi_hit = err_q;
endmodule

// File: tb/tb_replacement_ctrl.sv
// tb_replacement_ctrl: directed table-driven bench for replacement_ctrl (CNT_W=4)
module tb_replacement_ctrl;
   logic       clk = 1'b0;
   logic       reset, acc_valid, refill_ack, cnt_clr;
   logic [6:0] acc_line;
   logic [7:0] acc_hit, rp_way_select;
   logic [2:0] rp_way_select_bin;
   logic       acc_ready, rp_write_en, refill_req, err_multi_hit;
   logic [7:0] rp_way_hit;
   logic [6:0] rp_line_addr, refill_line;
   logic [2:0] refill_way;
   logic [3:0] hit_cnt, miss_cnt;
   int         n_chk = 0;
   int         n_fail = 0;

   typedef struct {
      logic [6:0] line;
      logic [7:0] hit;
      logic [2:0] sel;
      int         dly;
      logic [7:0] exp_way;
      logic [3:0] exp_hc;
      logic [3:0] exp_mc;
      logic       exp_err;
   } vec_t;
   vec_t vecs[8];

   replacement_ctrl #(.N_WAYS(8), .LINE_OFF_W(7), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .acc_valid(acc_valid), .acc_ready(acc_ready),
      .acc_line(acc_line), .acc_hit(acc_hit), .rp_write_en(rp_write_en),
      .rp_way_hit(rp_way_hit), .rp_line_addr(rp_line_addr),
      .rp_way_select(rp_way_select), .rp_way_select_bin(rp_way_select_bin),
      .refill_req(refill_req), .refill_way(refill_way), .refill_line(refill_line),
      .refill_ack(refill_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
      .cnt_clr(cnt_clr), .err_multi_hit(err_multi_hit)
   );

   always #5 clk = ~clk;
   assign rp_way_select = 8'd1 << rp_way_select_bin;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_access(input vec_t v);
      chk("idle_ready", acc_ready, 1);
      acc_valid = 1'b1;
      acc_line = v.line;
      acc_hit = v.hit;
      rp_way_select_bin = v.sel;
      step();
      acc_valid = 1'b0;
      if (v.hit == 8'h00) begin
         chk("select_no_req", refill_req, 0);
         chk("select_busy", acc_ready, 0);
         step();
         rp_way_select_bin = ~v.sel;
         for (int i = 0; i < v.dly; i++) begin
            chk("refill_req", refill_req, 1);
            chk("refill_way", refill_way, v.sel);
            chk("refill_line", refill_line, v.line);
            chk("refill_no_wr", rp_write_en, 0);
            step();
         end
         refill_ack = 1'b1;
         chk("refill_req_ack", refill_req, 1);
         step();
         refill_ack = 1'b0;
         chk("upd_no_req", refill_req, 0);
      end
      chk("upd_wr", rp_write_en, 1);
      chk("upd_way", rp_way_hit, v.exp_way);
      chk("upd_line", rp_line_addr, v.line);
      chk("upd_busy", acc_ready, 0);
      step();
      chk("post_wr", rp_write_en, 0);
      chk("post_way", rp_way_hit, 0);
      chk("post_ready", acc_ready, 1);
      chk("hit_cnt", hit_cnt, v.exp_hc);
      chk("miss_cnt", miss_cnt, v.exp_mc);
      chk("err", err_multi_hit, v.exp_err);
   endtask

   initial begin
      vecs[0] = '{7'd5,   8'h04, 3'd0, 0, 8'h04, 4'd1, 4'd0, 1'b0};
      vecs[1] = '{7'd9,   8'h00, 3'd3, 4, 8'h08, 4'd1, 4'd1, 1'b0};
      vecs[2] = '{7'd127, 8'h80, 3'd0, 0, 8'h80, 4'd2, 4'd1, 1'b0};
      vecs[3] = '{7'd0,   8'h00, 3'd7, 0, 8'h80, 4'd2, 4'd2, 1'b0};
      vecs[4] = '{7'd64,  8'h00, 3'd0, 2, 8'h01, 4'd2, 4'd3, 1'b0};
      vecs[5] = '{7'd33,  8'h01, 3'd0, 0, 8'h01, 4'd3, 4'd3, 1'b0};
      vecs[6] = '{7'd12,  8'h11, 3'd0, 0, 8'h11, 4'd4, 4'd3, 1'b1};
      vecs[7] = '{7'd3,   8'h02, 3'd0, 0, 8'h02, 4'd5, 4'd3, 1'b1};
      reset = 1'b1;
      acc_valid = 1'b0;
      refill_ack = 1'b0;
      cnt_clr = 1'b0;
      acc_line = 7'd0;
      acc_hit = 8'h00;
      rp_way_select_bin = 3'd0;
      repeat (3) step();
      reset = 1'b0;
      chk("rst_ready", acc_ready, 1);
      chk("rst_wr", rp_write_en, 0);
      chk("rst_way", rp_way_hit, 0);
      chk("rst_req", refill_req, 0);
      chk("rst_rway", refill_way, 0);
      chk("rst_rline", refill_line, 0);
      chk("rst_line", rp_line_addr, 0);
      chk("rst_hc", hit_cnt, 0);
      chk("rst_mc", miss_cnt, 0);
      chk("rst_err", err_multi_hit, 0);
      for (int i = 0; i < 8; i++) do_access(vecs[i]);

      // stray ack in IDLE, then a miss with acc_valid held high throughout
      refill_ack = 1'b1;
      step();
      refill_ack = 1'b0;
      chk("stray_ack_ready", acc_ready, 1);
      chk("stray_ack_req", refill_req, 0);
      chk("stray_ack_wr", rp_write_en, 0);
      acc_valid = 1'b1;
      acc_line = 7'd20;
      acc_hit = 8'h00;
      rp_way_select_bin = 3'd5;
      step();
      acc_line = 7'd99;
      acc_hit = 8'h04;
      chk("bp_sel_busy", acc_ready, 0);
      step();
      rp_way_select_bin = 3'd1;
      chk("bp_req", refill_req, 1);
      chk("bp_rway", refill_way, 5);
      repeat (2) step();
      chk("bp_busy", acc_ready, 0);
      chk("bp_line", rp_line_addr, 20);
      chk("bp_rline", refill_line, 20);
      chk("bp_hc", hit_cnt, 5);
      chk("bp_mc", miss_cnt, 4);
      refill_ack = 1'b1;
      step();
      refill_ack = 1'b0;
      acc_valid = 1'b0;
      chk("bp_wr", rp_write_en, 1);
      chk("bp_way", rp_way_hit, 8'h20);
      chk("bp_upd_line", rp_line_addr, 20);
      step();
      chk("bp_done_ready", acc_ready, 1);
      chk("bp_done_hc", hit_cnt, 5);
      chk("bp_done_mc", miss_cnt, 4);

      // clear, saturate, then clear racing a hit
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr_hc", hit_cnt, 0);
      chk("clr_mc", miss_cnt, 0);
      chk("clr_err_kept", err_multi_hit, 1);
      acc_hit = 8'h02;
      for (int i = 0; i < 17; i++) begin
         acc_valid = 1'b1;
         acc_line = 7'(i);
         step();
         acc_valid = 1'b0;
         step();
      end
      chk("sat_hc", hit_cnt, 15);
      chk("sat_mc", miss_cnt, 0);
      acc_valid = 1'b1;
      cnt_clr = 1'b1;
      step();
      acc_valid = 1'b0;
      cnt_clr = 1'b0;
      chk("clr_race_hc", hit_cnt, 0);
      chk("clr_race_wr", rp_write_en, 1);
      step();
      chk("clr_race_hc2", hit_cnt, 0);

      // reset while refilling
      acc_valid = 1'b1;
      acc_line = 7'd40;
      acc_hit = 8'h00;
      rp_way_select_bin = 3'd6;
      step();
      acc_valid = 1'b0;
      step();
      chk("mid_req", refill_req, 1);
      chk("mid_mc", miss_cnt, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mrst_req", refill_req, 0);
      chk("mrst_ready", acc_ready, 1);
      chk("mrst_wr", rp_write_en, 0);
      chk("mrst_hc", hit_cnt, 0);
      chk("mrst_mc", miss_cnt, 0);
      chk("mrst_err", err_multi_hit, 0);
      chk("mrst_rway", refill_way, 0);
      chk("mrst_line", rp_line_addr, 0);
      step();
      chk("mrst_wr2", rp_write_en, 0);
      chk("mrst_ready2", acc_ready, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/replacement_ctrl.md
REPLACEMENT_CTRL -- requirements
Module: replacement_ctrl

Interface
REQ-001 SHALL have parameter N_WAYS, default 8, number of cache ways (power of 2, >=2).
REQ-002 SHALL have parameter LINE_OFF_W, default 7, line-index width.
REQ-003 SHALL have parameter NWAY_W, default $clog2(N_WAYS), way-index width.
REQ-004 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports acc_valid input 1, acc_ready output 1: front-end access handshake.
REQ-008 SHALL have ports acc_line input LINE_OFF_W (accessed line) and acc_hit input N_WAYS (one-hot hit vector; all-zero means miss).
REQ-009 SHALL have ports rp_write_en output 1, rp_way_hit output N_WAYS, rp_line_addr output LINE_OFF_W: update interface to the replacement-policy block.
REQ-010 SHALL have ports rp_way_select input N_WAYS, rp_way_select_bin input NWAY_W: victim from the replacement-policy block.
REQ-011 SHALL have ports refill_req output 1, refill_way output NWAY_W, refill_line output LINE_OFF_W, refill_ack input 1: back-end line-fill handshake.
REQ-012 SHALL have ports hit_cnt output CNT_W, miss_cnt output CNT_W, cnt_clr input 1, err_multi_hit output 1.

Function
REQ-013 SHALL implement FSM states IDLE, SELECT, REFILL, UPDATE; acc_ready=1 only in IDLE.
REQ-014 SHALL accept an access on a cycle with acc_valid & acc_ready, latching acc_line into line_q and acc_hit into hit_q.
REQ-015 SHALL drive rp_line_addr=line_q in every state; line_q changes only on acceptance.
REQ-016 SHALL go IDLE->UPDATE on accepted hit (|acc_hit), with rp_way_hit=hit_q during UPDATE.
REQ-017 SHALL go IDLE->SELECT on accepted miss; in SELECT capture rp_way_select_bin into vict_q and go to REFILL next edge.
REQ-018 SHALL assert refill_req continuously in REFILL, with refill_way=vict_q and refill_line=line_q stable until acknowledged.
REQ-019 SHALL leave REFILL on the edge where refill_req & refill_ack, entering UPDATE with rp_way_hit=one-hot(vict_q).
REQ-020 SHALL assert rp_write_en for exactly one cycle, only in UPDATE, then return to IDLE.
REQ-021 SHALL drive rp_way_hit=0 and refill_way/refill_line as held registers when not in UPDATE/REFILL respectively.
REQ-022 SHALL ignore refill_ack outside REFILL and acc_valid outside IDLE.
REQ-023 Latency: hit accepted at cycle T -> rp_write_en at T+1, acc_ready at T+2; miss accepted at T -> refill_req first at T+2, rp_write_en one cycle after ack edge.
REQ-024 SHALL increment hit_cnt on accepted hit, miss_cnt on accepted miss; both saturate at all-ones.
REQ-025 SHALL zero both counters when cnt_clr=1; cnt_clr wins over simultaneous increment.
REQ-026 SHALL set sticky err_multi_hit when an accepted acc_hit has more than one bit set; the access still proceeds as a hit with hit_q unchanged.

Reset
REQ-027 SHALL, on reset=1 at a rising edge, enter IDLE, zero line_q, hit_q, vict_q, counters, err_multi_hit.
REQ-028 Reset values: acc_ready=1 after reset deasserts; rp_write_en=0, rp_way_hit=0, refill_req=0, refill_way=0, refill_line=0, rp_line_addr=0.
REQ-029 SHALL abort any in-progress REFILL or UPDATE on reset with no rp_write_en pulse issued.

Verification
REQ-030 Hit: acc_line=5, acc_hit=8'b0000_0100 accepted at T -> T+1 rp_write_en=1, rp_way_hit=8'b0000_0100, rp_line_addr=5; hit_cnt=1.
REQ-031 Miss: acc_line=9, acc_hit=0, rp_way_select_bin=3 -> refill_req from T+2, refill_way=3, refill_line=9; ack after 4 cycles -> next cycle rp_write_en=1, rp_way_hit=8'b0000_1000; miss_cnt=1.
REQ-032 Backpressure: acc_valid held high during REFILL -> acc_ready=0, no second acceptance until back in IDLE; refill_ack pulsed in IDLE has no effect.
REQ-033 Saturation/clear: CNT_W=4, 17 hits -> hit_cnt=15; cnt_clr with simultaneous hit -> hit_cnt=0.
REQ-034 Multi-hit: acc_hit=8'b0001_0001 -> err_multi_hit=1 until reset, rp_way_hit=8'b0001_0001 in UPDATE.
REQ-035 Reset mid-REFILL: reset asserted while refill_req=1 -> next edge refill_req=0, IDLE, counters 0, no rp_write_en.
